spi_slave: RTL and testbench

SPI slave endpoint on the far side of the SPI link from `spi_master`: it consumes the master's `sclk`/`chip_select`/`mosi` and drives `miso`. The block runs entirely in the local `clk` domain, oversampling and synchronising the SPI pins. Received words go to a parallel bus; words to transmit come from a one-entry parallel holding buffer. Fixed mode 0 (CPOL=0, CPHA=0), MSB/most-significant lane group first.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync.sv | 21 ++
 rtl/spi_slave.sv | 159 +++++++++++++++
 tb/tb_spi_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_master / spi_slave pair.
// Fixed mode 0: sclk idles low, data is sampled on the rising edge.
package spi_pkg;
  typedef enum logic {SLV_IDLE, SLV_SHIFT} spi_slv_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for asynchronous SPI pins, with a selectable reset level.
module spi_sync #(
  parameter int   WIDTH     = 1,
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sync_q <= {(STAGES*WIDTH){RESET_VAL}};
    else if (en_i) sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled in the clk domain: RX word to a parallel bus,
// TX words from a one-entry holding buffer, back-to-back words while cs_n stays low.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SIZE_BUS_SPI = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  input  logic [SIZE_BUS_SPI-1:0] spi_mosi,
  output logic [SIZE_BUS_SPI-1:0] spi_miso,
  output logic                    spi_miso_oe,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_valid,
  output logic                    underrun
);
  localparam int L     = SIZE_BUS_SPI;
  localparam int BEATS = DATA_WIDTH / SIZE_BUS_SPI;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic         sclk_s, csn_s;
  logic [L-1:0] mosi_s;

  spi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .en_i(clk_en), .d_i(spi_sclk), .q_o(sclk_s));
  spi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .en_i(clk_en), .d_i(spi_cs_n), .q_o(csn_s));
  spi_sync #(.WIDTH(L), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .en_i(clk_en), .d_i(spi_mosi), .q_o(mosi_s));

  logic sclk_q, csn_q;
  logic rise, fall, cs_fall, cs_rise;

  spi_slv_state_t  state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d, buf_q, buf_d;
  logic rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic done_q, done_d, skip_q, skip_d, full_q, full_d;
  logic load, wr;

  assign rise    =  sclk_s & ~sclk_q;
  assign fall    = ~sclk_s &  sclk_q;
  assign cs_fall = ~csn_s  &  csn_q;
  assign cs_rise =  csn_s  & ~csn_q;
  assign wr      = tx_valid & ~full_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    buf_d      = buf_q;
    skip_d     = skip_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      SLV_IDLE: begin
        if (cs_fall) begin
          state_d = SLV_SHIFT;
          beat_d  = '0;
          skip_d  = 1'b0;
          load    = 1'b1;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d = SLV_IDLE;
          beat_d  = '0;
          skip_d  = 1'b0;
        end else begin
          if (rise) begin
            rx_sr_d = (rx_sr_q << L) | DATA_WIDTH'(mosi_s);
            if (beat_q == CW'(BEATS - 1)) begin
              beat_d = '0;
              done_d = 1'b1;
            end else begin
              beat_d = beat_q + CW'(1);
            end
          end
          // The fall right after a reload must not shift away the new MSB group.
          if (fall) begin
            if (skip_q) skip_d  = 1'b0;
            else        tx_sr_d = tx_sr_q << L;
          end
          if (done_q) begin
            load   = 1'b1;
            skip_d = 1'b1;
          end
        end
      end
    endcase

    if (done_q) begin
      rx_data_d  = rx_sr_q;
      rx_valid_d = 1'b1;
    end

    if (load) begin
      tx_sr_d    = full_q ? buf_q : '0;
      underrun_d = ~full_q;
    end

    // A write can only land while empty, so it never collides with the loaded word.
    full_d = wr | (full_q & ~load);
    if (wr) buf_d = tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= SPI_CPOL;
      csn_q      <= 1'b1;
      state_q    <= SLV_IDLE;
      beat_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      skip_q     <= 1'b0;
      full_q     <= 1'b0;
    end else if (clk_en) begin
      sclk_q     <= sclk_s;
      csn_q      <= csn_s;
      state_q    <= state_d;
      beat_q     <= beat_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      buf_q      <= buf_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      skip_q     <= skip_d;
      full_q     <= full_d;
    end
  end

  assign spi_miso_oe = (state_q == SLV_SHIFT);
  assign spi_miso    = spi_miso_oe ? tx_sr_q[DATA_WIDTH-1 -: L] : '0;
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a 1-lane and a 4-lane instance driven by a mode-0 master
// model, with a transaction-level reference for the buffer, RX words and underruns.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int S = 2;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic [1:0]  cs_n;
  logic [3:0]  mosi;
  logic [15:0] tx_data;
  logic [1:0]  tv, oe, txr, rxv, und;
  logic [1:0][15:0] rxd;
  logic [0:0]  miso1;
  logic [3:0]  miso4;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(16), .SIZE_BUS_SPI(1), .SYNC_STAGES(S)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .spi_sclk(sclk), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi[0:0]), .spi_miso(miso1), .spi_miso_oe(oe[0]), .tx_data(tx_data),
    .tx_valid(tv[0]), .tx_ready(txr[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]), .underrun(und[0]));

  spi_slave #(.DATA_WIDTH(16), .SIZE_BUS_SPI(4), .SYNC_STAGES(S)) u4 (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .spi_sclk(sclk), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi), .spi_miso(miso4), .spi_miso_oe(oe[1]), .tx_data(tx_data),
    .tx_valid(tv[1]), .tx_ready(txr[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]), .underrun(und[1]));

  typedef struct {int due; int d; logic [15:0] w;} ev_t;
  ev_t rxq[$];
  ev_t unq[$];

  int          cyc = 0;
  int          tests = 0, fails = 0;
  logic [1:0]  bfull;
  logic [15:0] bval [2];
  logic [15:0] mrx  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word start: the buffer hands over its word, or zeros plus an underrun pulse.
  task automatic mload(input int d, input int due, output logic [15:0] w);
    if (bfull[d]) begin
      bfull[d] = 1'b0;
      w = bval[d];
    end else begin
      unq.push_back('{due, d, 16'h0});
      w = 16'h0;
    end
  endtask

  task automatic wr(input int d, input logic [15:0] w);
    chk("tx_ready_at_write", {31'd0, txr[d]}, {31'd0, ~bfull[d]});
    tx_data = w;
    tv[d] = 1'b1;
    step();
    tv[d] = 1'b0;
    bval[d] = w;
    bfull[d] = 1'b1;
  endtask

  function automatic logic [3:0] lane(input logic [31:0] mo, input int b, input int l);
    logic [31:0] m;
    if (l * (b + 1) > 32) return 4'h0;
    m = mo >> (32 - l * (b + 1));
    return m[3:0] & 4'((1 << l) - 1);
  endfunction

  // Master: cs low, per beat sample miso then raise sclk, change mosi on the fall.
  task automatic xfer(input int d, input int nbeats, input logic [31:0] mo, output logic [31:0] got);
    int l, bpw, bw;
    logic [15:0] txw, rxw;
    logic [3:0]  mis, grp;
    logic [15:0] sh;
    l = d ? 4 : 1;
    bpw = 16 / l;
    got = 0;
    rxw = 0;
    cs_n[d] = 1'b0;
    mload(d, cyc + S + 1, txw);
    mosi = lane(mo, 0, l);
    repeat (H) step();
    for (int b = 0; b < nbeats; b++) begin
      bw = b % bpw;
      sh = txw >> (16 - l * (bw + 1));
      grp = sh[3:0] & 4'((1 << l) - 1);
      mis = d ? miso4 : {3'b0, miso1};
      chk("miso_lane", {28'd0, mis}, {28'd0, grp});
      chk("miso_oe", {31'd0, oe[d]}, 32'd1);
      chk("tx_ready", {31'd0, txr[d]}, {31'd0, ~bfull[d]});
      got = (got << l) | 32'(mis);
      rxw = (rxw << l) | 16'(mosi & 4'((1 << l) - 1));
      sclk = 1'b1;
      if (bw == bpw - 1) begin
        rxq.push_back('{cyc + S + 2, d, rxw});
        mload(d, cyc + S + 2, txw);
      end
      repeat (H) step();
      sclk = 1'b0;
      mosi = lane(mo, b + 1, l);
      repeat (H) step();
    end
    cs_n[d] = 1'b1;
    repeat (2 * H) step();
    chk("oe_after_cs", {31'd0, oe[d]}, 32'd0);
  endtask

  // Per-cycle comparison of the event outputs against the reference queues.
  always @(negedge clk) begin
    logic [1:0] erx, eun;
    logic [3:0] mis;
    if (rst_n === 1'b1) begin
      erx = 2'b00;
      eun = 2'b00;
      if (rxq.size() > 0 && rxq[0].due == cyc) begin
        erx[rxq[0].d] = 1'b1;
        mrx[rxq[0].d] = rxq[0].w;
        void'(rxq.pop_front());
      end
      if (unq.size() > 0 && unq[0].due == cyc) begin
        eun[unq[0].d] = 1'b1;
        void'(unq.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
        chk("rx_valid", {31'd0, rxv[d]}, {31'd0, erx[d]});
        chk("rx_data", {16'd0, rxd[d]}, {16'd0, mrx[d]});
        chk("underrun", {31'd0, und[d]}, {31'd0, eun[d]});
        mis = d ? miso4 : {3'b0, miso1};
        if (oe[d] == 1'b0) chk("idle_miso", {28'd0, mis}, 32'd0);
      end
    end
  end

  task automatic reset_outs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rx_valid"}, {31'd0, rxv[d]}, 32'd0);
      chk({tag, "_underrun"}, {31'd0, und[d]}, 32'd0);
      chk({tag, "_oe"}, {31'd0, oe[d]}, 32'd0);
      chk({tag, "_tx_ready"}, {31'd0, txr[d]}, 32'd1);
      chk({tag, "_rx_data"}, {16'd0, rxd[d]}, 32'd0);
    end
    chk({tag, "_miso1"}, {31'd0, miso1}, 32'd0);
    chk({tag, "_miso4"}, {28'd0, miso4}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int d, nb, bpw;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 2'b11; mosi = '0;
    tx_data = '0; tv = '0; bfull = '0;
    mrx[0] = '0; mrx[1] = '0; bval[0] = '0; bval[1] = '0;
    repeat (3) step();
    reset_outs("reset");
    rst_n = 1'b1;
    repeat (4) step();

    // Single word
    wr(0, 16'hA5C3);
    repeat (4) step();
    xfer(0, 16, {16'h1234, 16'h0}, got);
    chk("single_master_rx", {16'd0, got[15:0]}, 32'h0000A5C3);
    chk("single_rx_data", {16'd0, rxd[0]}, 32'h00001234);

    // Back-to-back: second word written mid-way through the first
    wr(0, 16'h1111);
    fork
      xfer(0, 32, 32'hDEADBEEF, got);
      begin
        repeat (60) step();
        wr(0, 16'h2222);
      end
    join
    chk("b2b_miso_stream", got, 32'h11112222);
    chk("b2b_rx_data", {16'd0, rxd[0]}, 32'h0000BEEF);

    // Underrun: nothing buffered
    xfer(0, 16, {16'h5A5A, 16'h0}, got);
    chk("underrun_miso_zero", {16'd0, got[15:0]}, 32'h0);
    chk("underrun_rx_data", {16'd0, rxd[0]}, 32'h00005A5A);

    // Abort after 7 beats, then a full word
    wr(0, 16'h7777);
    xfer(0, 7, 32'hFFFF0000, got);
    chk("abort_rx_held", {16'd0, rxd[0]}, 32'h00005A5A);
    wr(0, 16'h3C3C);
    xfer(0, 16, {16'h0F0F, 16'h0}, got);
    chk("after_abort_master", {16'd0, got[15:0]}, 32'h00003C3C);
    chk("after_abort_rx", {16'd0, rxd[0]}, 32'h00000F0F);

    // Quad lane
    wr(1, 16'hBEEF);
    xfer(1, 4, {16'hCAFE, 16'h0}, got);
    chk("quad_master_rx", {16'd0, got[15:0]}, 32'h0000BEEF);
    chk("quad_rx_data", {16'd0, rxd[1]}, 32'h0000CAFE);

    // Reset in the middle of a word
    wr(0, 16'h9999);
    cs_n[0] = 1'b0;
    bfull[0] = 1'b0;
    repeat (H) step();
    for (int b = 0; b < 5; b++) begin
      mosi = 4'($urandom_range(0, 1));
      sclk = 1'b1; repeat (H) step();
      sclk = 1'b0; repeat (H) step();
    end
    rst_n = 1'b0;
    rxq.delete(); unq.delete();
    bfull = '0; mrx[0] = '0; mrx[1] = '0;
    step();
    reset_outs("midword_reset");
    cs_n[0] = 1'b1;
    repeat (4) step();
    rst_n = 1'b1;
    repeat (4) step();
    wr(0, 16'h6E6E);
    xfer(0, 16, {16'h8421, 16'h0}, got);
    chk("post_reset_master", {16'd0, got[15:0]}, 32'h00006E6E);
    chk("post_reset_rx", {16'd0, rxd[0]}, 32'h00008421);

    // Randomized transfers on either instance
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 1);
      bpw = d ? 4 : 16;
      if ($urandom_range(0, 3) != 0) wr(d, 16'($urandom));
      case ($urandom_range(0, 3))
        0:       nb = $urandom_range(1, bpw - 1);
        1:       nb = 2 * bpw;
        default: nb = bpw;
      endcase
      xfer(d, nb, $urandom, got);
    end

    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
